// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC sequencer: vector defaults,
// redirect-cause encoding and the jump-target alignment helper.
package pc_pkg;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC  = 32'h0000_0100;

  typedef enum logic [2:0] {
    RD_SEQ,
    RD_JUMP,
    RD_TRAP,
    RD_MRET,
    RD_MISALIGN
  } redir_e;

  function automatic logic is_misaligned(
    input logic [1:0] lo
  );
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the
// oldest entry, a pop when empty does nothing.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic            do_pop;
  logic [PW-1:0]   top_idx;

  assign top_idx = ptr_q - PW'(1);
  assign do_pop  = i_pop && (cnt_q != '0);

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    // pop-then-push collapses to replacing the top in place
    if (do_pop && i_push) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (do_pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end else if (i_push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= i_data;
    end
  end

  assign o_valid = cnt_q != '0;
  assign o_top   = o_valid ? mem_q[top_idx] : '0;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC generator with trap/mret/jump redirect and EPC capture.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load_PC,
  input  logic            i_jump_DV,
  input  logic [XLEN-1:0] i_jump_address,
  input  logic            i_trap,
  input  logic            i_mret,
  input  logic            i_epc_wr,
  input  logic [XLEN-1:0] i_epc_wdata,
  input  logic            i_call,
  input  logic            i_ret,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_PC_prev,
  output logic [XLEN-1:0] o_epc,
  output logic [XLEN-1:0] o_badaddr,
  output logic            o_misaligned,
  output logic [XLEN-1:0] o_ras_top,
  output logic            o_ras_valid
);

  redir_e          cause;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] prev_q, prev_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc = pc_q + XLEN'(4);

  always_comb begin
    if (i_trap)
      cause = RD_TRAP;
    else if (i_mret)
      cause = RD_MRET;
    else if (i_jump_DV && is_misaligned(i_jump_address[1:0]))
      cause = RD_MISALIGN;
    else if (i_jump_DV)
      cause = RD_JUMP;
    else
      cause = RD_SEQ;
  end

  always_comb begin
    pc_d   = pc_q;
    prev_d = prev_q;
    epc_d  = epc_q;
    bad_d  = bad_q;
    mis_d  = 1'b0;
    if (i_load_PC) begin
      prev_d = pc_q;
      unique case (cause)
        RD_TRAP:     pc_d = TRAP_VEC;
        RD_MRET:     pc_d = epc_q;
        RD_MISALIGN: begin
          pc_d  = TRAP_VEC;
          bad_d = i_jump_address;
          mis_d = 1'b1;
        end
        RD_JUMP:     pc_d = i_jump_address;
        default:     pc_d = pc_inc;
      endcase
    end
    // hardware capture outranks a CSR write in the same cycle
    if (i_load_PC && (cause == RD_TRAP || cause == RD_MISALIGN))
      epc_d = pc_q;
    else if (i_epc_wr)
      epc_d = {i_epc_wdata[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q   <= RESET_VEC;
      prev_q <= RESET_VEC;
      epc_q  <= '0;
      bad_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      prev_q <= prev_d;
      epc_q  <= epc_d;
      bad_q  <= bad_d;
      mis_q  <= mis_d;
    end
  end

  assign o_PC         = pc_q;
  assign o_PC_prev    = prev_q;
  assign o_epc        = epc_q;
  assign o_badaddr    = bad_q;
  assign o_misaligned = mis_q;

  logic [1:0] unused_epc_lo;
  assign unused_epc_lo = i_epc_wdata[1:0];

`ifdef PC_RAS_EN
  logic ras_push, ras_pop;
  assign ras_push = i_load_PC && cause == RD_JUMP && i_call;
  assign ras_pop  = i_load_PC && cause == RD_JUMP && i_ret;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (ras_push),
    .i_pop   (ras_pop),
    .i_data  (pc_inc),
    .o_top   (o_ras_top),
    .o_valid (o_ras_valid)
  );
`else
  logic [RAS_DEPTH-1:0] unused_ras;
  assign unused_ras  = {RAS_DEPTH{i_call ^ i_ret}};
  assign o_ras_top   = '0;
  assign o_ras_valid = 1'b0;
`endif

endmodule
